// File: rtl/bcd_to_bin_seq_if.sv
// bcd_to_bin_seq_if: start/busy/done handshake and operand/result bus of the BCD-to-binary converter
// master drives start/num_BCD and observes busy/done/num_bin/err; slave is the converter side.
interface bcd_to_bin_seq_if #(
  parameter int N_DIG = 4,
  parameter int BIN_W = 16
);
  logic             start;
  logic [4*N_DIG-1:0] num_BCD;
  logic             busy;
  logic             done;
  logic [BIN_W-1:0] num_bin;
  logic             err;
  modport master(output start, num_BCD, input busy, done, num_bin, err);
  modport slave(input start, num_BCD, output busy, done, num_bin, err);
endinterface

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential BCD-to-binary converter (reverse double dabble, one iteration per clock)
// Ports: clk; rst (sync, active-high); bus (slave): start, num_BCD in; busy, done, num_bin, err out.
// busy is high in CONV, done is a one-cycle pulse with num_bin/err valid; num_bin holds until next done.
// Optional: define BCD_CHECK_EN to reject operands with a digit above 9 (done next cycle, err=1, num_bin=0).
module bcd_to_bin_seq #(
  parameter int N_DIG = 4,
  parameter int BIN_W = 16
) (
  input logic clk,
  input logic rst,
  bcd_to_bin_seq_if.slave bus
);
  localparam int BW = 4 * N_DIG;
  localparam int CW = $clog2(BIN_W);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t state_q, state_d;
  logic [BW+BIN_W-1:0] sr_q, sr_d, sr_nx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] num_bin_q, num_bin_d;
  logic err_q, err_d, bad;
  // shift right, then pull every BCD nibble that reached 8 or more back by 3
  always_comb begin
    sr_nx = sr_q >> 1;
    for (int i = 0; i < N_DIG; i++)
      sr_nx[BIN_W+4*i +: 4] = sr_nx[BIN_W+4*i +: 4] >= 4'd8 ? sr_nx[BIN_W+4*i +: 4] - 4'd3
                                                            : sr_nx[BIN_W+4*i +: 4];
  end
`ifdef BCD_CHECK_EN
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < N_DIG; i++)
      bad = bad | (bus.num_BCD[4*i +: 4] > 4'd9);
  end
`else
  assign bad = 1'b0;
`endif
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    num_bin_d = num_bin_q;
    err_d     = err_q;
    case (state_q)
      IDLE: if (bus.start) begin
        if (bad) begin
          state_d   = DONE;
          err_d     = 1'b1;
          num_bin_d = '0;
        end else begin
          state_d = CONV;
          sr_d    = {bus.num_BCD, {BIN_W{1'b0}}};
          cnt_d   = '0;
        end
      end
      CONV: begin
        sr_d  = sr_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(BIN_W - 1)) begin
          state_d   = DONE;
          num_bin_d = sr_nx[BIN_W-1:0];
          err_d     = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      num_bin_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      num_bin_q <= num_bin_d;
      err_q     <= err_d;
    end
  end
  assign bus.busy    = state_q == CONV;
  assign bus.done    = state_q == DONE;
  assign bus.num_bin = num_bin_q;
  assign bus.err     = err_q;
endmodule
